simp_sequencer: RTL and testbench

- Control sequencer for the SIMP datapath. Drives the load-enable inputs of the IR (8-bit), PC (5-bit) and ACC (8-bit) holding registers, plus the address mux, ALU-op and memory strobes.
- Runs a fetch/decode/execute loop over 8-bit instructions: opcode in [7:5], operand address in [4:0].
- Talks to memory through a ready handshake and bounds wait states with a timeout.

---
 rtl/simp_sequencer.sv | 146 ++++++++++++++
 tb/tb_simp_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simp_sequencer.sv
// Fetch/decode/execute control sequencer for the SIMP datapath.
// Holds the state and wait-counter registers; datapath controls are decoded from them.
module simp_sequencer #(
   parameter int WAIT_MAX = 15,
   parameter int TW       = 4
) (
   input  logic       ck,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] ir,
   input  logic       acc_zero,
   input  logic       mem_rdy,
   output logic       ir_e,
   output logic       pc_e,
   output logic       pc_sel,
   output logic       acc_e,
   output logic [1:0] alu_op,
   output logic       addr_sel,
   output logic       mem_re,
   output logic       mem_we,
   output logic       halted,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [TW-1:0] C_WAIT = TW'(WAIT_MAX);

   state_t        r_state;
   state_t        w_next;
   logic [TW-1:0] r_cnt;
   logic          r_fault;
   logic          w_timeout;
   logic          w_strobe;
   logic [2:0]    w_op;
   logic          w_unused_operand;

   assign w_op             = ir[7:5];
   assign w_unused_operand = ^ir[4:0];
   assign w_strobe         = mem_re | mem_we;
   assign state            = r_state;
   assign fault            = r_fault;

   // Output decode and next-state selection.
   always_comb begin
      ir_e      = 1'b0;
      pc_e      = 1'b0;
      pc_sel    = 1'b0;
      acc_e     = 1'b0;
      alu_op    = 2'b00;
      addr_sel  = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      halted    = 1'b0;
      w_timeout = 1'b0;
      w_next    = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_FETCH;
            else       w_next = S_IDLE;
         end
         S_FETCH: begin
            mem_re = 1'b1;
            if (mem_rdy) begin
               ir_e   = 1'b1;
               pc_e   = 1'b1;
               w_next = S_DECODE;
            end else if (r_cnt == C_WAIT) begin
               w_timeout = 1'b1;
               w_next    = S_HALT;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            case (w_op)
               3'd0, 3'd1, 3'd2, 3'd3: w_next = S_EXEC;
               3'd4: begin
                  pc_e   = 1'b1;
                  pc_sel = 1'b1;
                  w_next = S_FETCH;
               end
               3'd5: begin
                  pc_e   = acc_zero;
                  pc_sel = acc_zero;
                  w_next = S_FETCH;
               end
               3'd6:    w_next = S_FETCH;
               3'd7:    w_next = S_HALT;
               default: w_next = S_FETCH;
            endcase
         end
         S_EXEC: begin
            addr_sel = 1'b1;
            case (w_op)
               3'd0, 3'd2, 3'd3: mem_re = 1'b1;
               3'd1:             mem_we = 1'b1;
               default:          mem_re = 1'b0;
            endcase
            // A non-memory opcode here can only mean IR changed underneath us; just refetch.
            if (!(mem_re | mem_we)) begin
               w_next = S_FETCH;
            end else if (mem_rdy) begin
               acc_e  = mem_re;
               alu_op = (w_op == 3'd2) ? 2'b01 : ((w_op == 3'd3) ? 2'b10 : 2'b00);
               w_next = S_FETCH;
            end else if (r_cnt == C_WAIT) begin
               w_timeout = 1'b1;
               w_next    = S_HALT;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) w_next = S_FETCH;
            else       w_next = S_HALT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State, wait counter and sticky fault.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= {TW{1'b0}};
         r_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) r_cnt <= {TW{1'b0}};
         else if (w_strobe && !mem_rdy) r_cnt <= r_cnt + TW'(1);
         else r_cnt <= r_cnt;
         if (w_timeout) r_fault <= 1'b1;
         else r_fault <= r_fault;
      end
   end

endmodule

// File: tb/tb_simp_sequencer.sv
// Self-checking bench for simp_sequencer: per-instruction cycle traces built from
// the instruction timing rules are compared cycle by cycle with the DUT outputs.
module tb_simp_sequencer;
   localparam int WAIT_MAX = 15;

   localparam logic [9:0] F_IRE  = 10'h200;
   localparam logic [9:0] F_PCE  = 10'h100;
   localparam logic [9:0] F_PCS  = 10'h080;
   localparam logic [9:0] F_ACCE = 10'h040;
   localparam logic [9:0] F_SUB  = 10'h020;
   localparam logic [9:0] F_ADD  = 10'h010;
   localparam logic [9:0] F_ASEL = 10'h008;
   localparam logic [9:0] F_RE   = 10'h004;
   localparam logic [9:0] F_WE   = 10'h002;
   localparam logic [9:0] F_HLT  = 10'h001;

   logic       ck = 1'b0;
   logic       rst, start, acc_zero, mem_rdy;
   logic [7:0] ir;
   logic       ir_e, pc_e, pc_sel, acc_e, addr_sel, mem_re, mem_we, halted, fault;
   logic [1:0] alu_op;
   logic [2:0] state;
   logic [13:0] obs;

   int errors = 0;
   int checks = 0;
   logic exp_fault;

   typedef struct {
      logic        go;
      logic        rdy;
      logic [7:0]  ir;
      logic        az;
      logic [13:0] exp;
   } cyc_t;
   cyc_t q[$];

   simp_sequencer #(.WAIT_MAX(WAIT_MAX), .TW(4)) dut (
      .ck(ck), .rst(rst), .start(start), .ir(ir), .acc_zero(acc_zero), .mem_rdy(mem_rdy),
      .ir_e(ir_e), .pc_e(pc_e), .pc_sel(pc_sel), .acc_e(acc_e), .alu_op(alu_op),
      .addr_sel(addr_sel), .mem_re(mem_re), .mem_we(mem_we), .halted(halted),
      .fault(fault), .state(state)
   );

   always #5 ck = ~ck;

   assign obs = {state, ir_e, pc_e, pc_sel, acc_e, alu_op, addr_sel, mem_re, mem_we, halted, fault};

   function automatic void push(input logic go, input logic rdy, input logic [7:0] i,
                                input logic z, input logic [2:0] st, input logic [9:0] f);
      cyc_t c;
      c.go = go; c.rdy = rdy; c.ir = i; c.az = z;
      c.exp = {st, f, exp_fault};
      q.push_back(c);
   endfunction

   // Expected trace of one instruction starting from a fresh FETCH.
   function automatic void model_instr(input logic [7:0] i, input logic z, input int wf, input int wx);
      logic [2:0] op;
      logic [9:0] f;
      op = i[7:5];
      for (int k = 0; k < wf; k++) push(1'b0, 1'b0, i, z, 3'd1, F_RE);
      push(1'b0, 1'b1, i, z, 3'd1, F_RE | F_IRE | F_PCE);
      f = 10'd0;
      if (op == 3'd4 || (op == 3'd5 && z)) f = F_PCE | F_PCS;
      push(1'b0, 1'($urandom_range(0, 1)), i, z, 3'd2, f);
      if (op < 3'd4) begin
         f = F_ASEL | ((op == 3'd1) ? F_WE : F_RE);
         for (int k = 0; k < wx; k++) push(1'b0, 1'b0, i, z, 3'd3, f);
         if (op == 3'd2)      f = f | F_ACCE | F_ADD;
         else if (op == 3'd3) f = f | F_ACCE | F_SUB;
         else if (op == 3'd0) f = f | F_ACCE;
         push(1'b0, 1'b1, i, z, 3'd3, f);
      end
   endfunction

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; mem_rdy = 1'b0; ir = 8'h00; acc_zero = 1'b0;
      exp_fault = 1'b0;
      q.delete();
      @(posedge ck); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; mem_rdy = 1'b1; ir = 8'hFF; acc_zero = 1'b1;
      exp_fault = 1'b0;
      @(negedge ck);
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs, 14'd0); end
      @(posedge ck); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge ck);
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL idle_outputs: got %h want %h", obs, 14'd0); end
      @(posedge ck); #1;
   endtask

   task automatic test_add();
      cyc_t c;
      do_reset();
      push(1'b1, 1'b0, 8'h45, 1'b0, 3'd0, 10'd0);
      model_instr(8'h45, 1'b0, 0, 0);
      model_instr(8'hC7, 1'b0, 0, 0);
      while (q.size() > 0) begin
         c = q.pop_front();
         start = c.go; mem_rdy = c.rdy; ir = c.ir; acc_zero = c.az;
         @(negedge ck);
         checks++;
         if (obs !== c.exp) begin errors++; $display("FAIL add_seq: ir=%h got %h want %h", c.ir, obs, c.exp); end
         @(posedge ck); #1;
      end
   endtask

   task automatic test_branches();
      cyc_t c;
      model_instr(8'h9C, 1'b0, 0, 0);
      model_instr(8'hA3, 1'b0, 0, 0);
      model_instr(8'hA3, 1'b1, 0, 0);
      model_instr(8'h9C, 1'b1, 1, 0);
      model_instr(8'h2A, 1'b0, 0, 2);
      model_instr(8'h07, 1'b1, 0, 0);
      model_instr(8'h7F, 1'b0, 2, 1);
      while (q.size() > 0) begin
         c = q.pop_front();
         start = c.go; mem_rdy = c.rdy; ir = c.ir; acc_zero = c.az;
         @(negedge ck);
         checks++;
         if (obs !== c.exp) begin errors++; $display("FAIL branch_seq: ir=%h az=%b got %h want %h", c.ir, c.az, obs, c.exp); end
         @(posedge ck); #1;
      end
   endtask

   task automatic test_fetch_wait();
      cyc_t c;
      model_instr(8'h61, 1'b0, 3, 0);
      model_instr(8'h01, 1'b0, WAIT_MAX, WAIT_MAX);
      model_instr(8'h3B, 1'b0, WAIT_MAX, WAIT_MAX);
      while (q.size() > 0) begin
         c = q.pop_front();
         start = c.go; mem_rdy = c.rdy; ir = c.ir; acc_zero = c.az;
         @(negedge ck);
         checks++;
         if (obs !== c.exp) begin errors++; $display("FAIL wait_seq: ir=%h got %h want %h", c.ir, obs, c.exp); end
         @(posedge ck); #1;
      end
   endtask

   task automatic test_random();
      cyc_t c;
      logic [7:0] i;
      for (int n = 0; n < 80; n++) begin
         i = {3'($urandom_range(0, 6)), 5'($urandom)};
         model_instr(i, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? WAIT_MAX : int'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0) ? WAIT_MAX : int'($urandom_range(0, 3)));
      end
      while (q.size() > 0) begin
         c = q.pop_front();
         start = c.go; mem_rdy = c.rdy; ir = c.ir; acc_zero = c.az;
         @(negedge ck);
         checks++;
         if (obs !== c.exp) begin errors++; $display("FAIL random_seq: ir=%h got %h want %h", c.ir, obs, c.exp); end
         @(posedge ck); #1;
      end
   endtask

   task automatic test_timeout();
      cyc_t c;
      do_reset();
      push(1'b1, 1'b0, 8'h10, 1'b0, 3'd0, 10'd0);
      for (int k = 0; k <= WAIT_MAX; k++) push(1'b0, 1'b0, 8'h10, 1'b0, 3'd1, F_RE);
      exp_fault = 1'b1;
      push(1'b0, 1'b1, 8'h10, 1'b0, 3'd4, F_HLT);
      push(1'b0, 1'b0, 8'h10, 1'b0, 3'd4, F_HLT);
      push(1'b1, 1'b0, 8'h10, 1'b0, 3'd4, F_HLT);
      push(1'b0, 1'b0, 8'h10, 1'b0, 3'd1, F_RE);
      model_instr(8'hC0, 1'b0, 1, 0);
      while (q.size() > 0) begin
         c = q.pop_front();
         start = c.go; mem_rdy = c.rdy; ir = c.ir; acc_zero = c.az;
         @(negedge ck);
         checks++;
         if (obs !== c.exp) begin errors++; $display("FAIL timeout_seq: got %h want %h", obs, c.exp); end
         @(posedge ck); #1;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b want 0", fault); end
      @(posedge ck); #1;
      rst = 1'b0;
   endtask

   task automatic test_halt();
      cyc_t c;
      do_reset();
      push(1'b1, 1'b0, 8'hE0, 1'b0, 3'd0, 10'd0);
      model_instr(8'hE0, 1'b0, 0, 0);
      push(1'b0, 1'b1, 8'hE0, 1'b0, 3'd4, F_HLT);
      push(1'b0, 1'b0, 8'hE0, 1'b1, 3'd4, F_HLT);
      push(1'b1, 1'b1, 8'hE0, 1'b0, 3'd4, F_HLT);
      model_instr(8'h4A, 1'b0, 0, 1);
      while (q.size() > 0) begin
         c = q.pop_front();
         start = c.go; mem_rdy = c.rdy; ir = c.ir; acc_zero = c.az;
         @(negedge ck);
         checks++;
         if (obs !== c.exp) begin errors++; $display("FAIL halt_seq: got %h want %h", obs, c.exp); end
         @(posedge ck); #1;
      end
   endtask

   task automatic test_async_reset();
      cyc_t c;
      push(1'b0, 1'b1, 8'h1F, 1'b0, 3'd1, F_RE | F_IRE | F_PCE);
      push(1'b0, 1'b0, 8'h1F, 1'b0, 3'd2, 10'd0);
      push(1'b0, 1'b0, 8'h1F, 1'b0, 3'd3, F_ASEL | F_RE);
      push(1'b0, 1'b0, 8'h1F, 1'b0, 3'd3, F_ASEL | F_RE);
      while (q.size() > 0) begin
         c = q.pop_front();
         start = c.go; mem_rdy = c.rdy; ir = c.ir; acc_zero = c.az;
         @(negedge ck);
         checks++;
         if (obs !== c.exp) begin errors++; $display("FAIL exec_wait_seq: got %h want %h", obs, c.exp); end
         @(posedge ck); #1;
      end
      @(negedge ck); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 14'd0) begin errors++; $display("FAIL async_reset: got %h want %h", obs, 14'd0); end
      @(posedge ck); #1;
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_branches();
      test_fetch_wait();
      test_random();
      test_timeout();
      test_halt();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
